// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, state encodings and the oversample constant.
package uart_pkg;
   localparam int OVERSAMPLE = 16;
   typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD} parity_t;
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
   function automatic logic par_on(parity_t p);
      return p == PAR_EVEN || p == PAR_ODD;
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO with extra-MSB pointers; head reads 0 while empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wptr, rptr;
   logic do_wr, do_rd;
   assign empty = wptr == rptr;
   assign full = wptr[AW] != rptr[AW] && wptr[AW-1:0] == rptr[AW-1:0];
   assign do_rd = rd_en && !empty;
   // a pop in the same clk frees the slot, so a push into a full FIFO still lands
   assign do_wr = wr_en && (!full || do_rd);
   assign rd_data = empty ? '0 : mem[rptr[AW-1:0]];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_wr) wptr <= wptr + 1'b1;
         if (do_rd) rptr <= rptr + 1'b1;
      end
   always_ff @(posedge clk)
      if (do_wr) mem[wptr[AW-1:0]] <= wr_data;
endmodule

// File: rtl/uart_fifo.sv
// uart_fifo: 16x-oversampled UART with TX/RX FIFOs, optional parity and sticky errors.
module uart_fifo
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [15:0]          baud_div,
   input  logic [1:0]           parity_mode,
   input  logic                 stop2,
   input  logic                 tx_wr_en,
   input  logic [DATA_BITS-1:0] tx_wr_data,
   output logic                 tx_full,
   output logic                 tx_empty,
   output logic                 tx_busy,
   output logic                 tx,
   input  logic                 rx,
   input  logic                 rx_rd_en,
   output logic [DATA_BITS-1:0] rx_rd_data,
   output logic                 rx_empty,
   output logic                 rx_full,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 rx_overrun,
   input  logic                 err_clr
);
   parity_t pm;
   logic [15:0] div, tcnt;
   logic tick;
   assign pm = parity_t'(parity_mode);
   assign div = baud_div == 16'd0 ? 16'd1 : baud_div;
   assign tick = tcnt >= div - 16'd1;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) tcnt <= '0;
      else tcnt <= tick ? '0 : tcnt + 16'd1;
   tx_state_t tx_st, tx_nx;
   logic [4:0] tx_cnt;
   logic [2:0] tx_bit;
   logic [DATA_BITS-1:0] tx_sh, tx_head;
   logic tx_par, tx_pen, tx_s2, tx_load, tx_bit_end;
   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst_n(rst_n), .wr_en(tx_wr_en), .wr_data(tx_wr_data),
      .rd_en(tx_load), .rd_data(tx_head), .full(tx_full), .empty(tx_empty)
   );
   assign tx_bit_end = tick && tx_cnt == ((tx_st == TX_STOP && tx_s2) ? 5'd31 : 5'd15);
   assign tx_busy = tx_st != TX_IDLE || !tx_empty;
   assign tx = tx_st == TX_START ? 1'b0 : tx_st == TX_DATA ? tx_sh[0] : tx_st == TX_PARITY ? tx_par : 1'b1;
   always_comb begin
      tx_nx = tx_st;
      tx_load = 1'b0;
      case (tx_st)
         TX_IDLE:   tx_load = tick && !tx_empty;
         TX_START:  if (tx_bit_end) tx_nx = TX_DATA;
         TX_DATA:   if (tx_bit_end && tx_bit == 3'(DATA_BITS-1)) tx_nx = tx_pen ? TX_PARITY : TX_STOP;
         TX_PARITY: if (tx_bit_end) tx_nx = TX_STOP;
         TX_STOP:   if (tx_bit_end) begin
            tx_load = !tx_empty;
            tx_nx = TX_IDLE;
         end
         default:   tx_nx = TX_IDLE;
      endcase
      if (tx_load) tx_nx = TX_START;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         tx_st <= TX_IDLE;
         tx_cnt <= '0;
         tx_bit <= '0;
         tx_sh <= '0;
         tx_par <= 1'b0;
         tx_pen <= 1'b0;
         tx_s2 <= 1'b0;
      end else begin
         tx_st <= tx_nx;
         if (tx_load) begin
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh <= tx_head;
            tx_par <= (pm == PAR_ODD) ^ (^tx_head);
            tx_pen <= par_on(pm);
            tx_s2 <= stop2;
         end else if (tick && tx_st != TX_IDLE) begin
            tx_cnt <= tx_bit_end ? '0 : tx_cnt + 5'd1;
            if (tx_bit_end && tx_st == TX_DATA) begin
               tx_sh <= tx_sh >> 1;
               tx_bit <= tx_bit + 3'd1;
            end
         end
      end
   rx_state_t rx_st, rx_nx;
   logic [1:0] rx_sync;
   logic rxs, rxs_q, mid, rx_end, rx_store, pe_set, fe_set, ov_set;
   logic [3:0] rx_cnt;
   logic [2:0] rx_bit;
   logic [DATA_BITS-1:0] rx_sh;
   logic rx_pen, rx_odd, rx_hold;
   assign rxs = rx_sync[1];
   assign mid = tick && rx_cnt == 4'd7;
   assign rx_end = tick && rx_cnt == 4'd15;
   assign rx_store = rx_st == RX_STOP && !rx_hold && mid && rxs;
   assign fe_set = rx_st == RX_STOP && !rx_hold && mid && !rxs;
   assign pe_set = rx_st == RX_PARITY && mid && (rxs != (rx_odd ^ (^rx_sh)));
   assign ov_set = rx_store && rx_full && !rx_rd_en;
   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst_n(rst_n), .wr_en(rx_store), .wr_data(rx_sh),
      .rd_en(rx_rd_en), .rd_data(rx_rd_data), .full(rx_full), .empty(rx_empty)
   );
   always_comb begin
      rx_nx = rx_st;
      case (rx_st)
         RX_IDLE:   if (rxs_q && !rxs) rx_nx = RX_START;
         RX_START:  if (mid && rxs) rx_nx = RX_IDLE; else if (rx_end) rx_nx = RX_DATA;
         RX_DATA:   if (rx_end && rx_bit == 3'(DATA_BITS-1)) rx_nx = rx_pen ? RX_PARITY : RX_STOP;
         RX_PARITY: if (rx_end) rx_nx = RX_STOP;
         RX_STOP:   if (rx_hold ? rxs : (mid && rxs)) rx_nx = RX_IDLE;
         default:   rx_nx = RX_IDLE;
      endcase
   end
   // rx_hold marks a broken stop bit: stay in STOP until the line returns high
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rx_sync <= 2'b11;
         rxs_q <= 1'b1;
         rx_st <= RX_IDLE;
         rx_cnt <= '0;
         rx_bit <= '0;
         rx_sh <= '0;
         rx_pen <= 1'b0;
         rx_odd <= 1'b0;
         rx_hold <= 1'b0;
         parity_err <= 1'b0;
         frame_err <= 1'b0;
         rx_overrun <= 1'b0;
      end else begin
         rx_sync <= {rx_sync[0], rx};
         rxs_q <= rxs;
         rx_st <= rx_nx;
         if (rx_st == RX_IDLE) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_hold <= 1'b0;
            rx_pen <= par_on(pm);
            rx_odd <= pm == PAR_ODD;
         end else if (tick) begin
            rx_cnt <= rx_cnt + 4'd1;
            if (mid && rx_st == RX_DATA) rx_sh <= {rxs, rx_sh[DATA_BITS-1:1]};
            if (rx_end && rx_st == RX_DATA) rx_bit <= rx_bit + 3'd1;
            if (fe_set) rx_hold <= 1'b1;
         end
         parity_err <= pe_set | (parity_err & ~err_clr);
         frame_err <= fe_set | (frame_err & ~err_clr);
         rx_overrun <= ov_set | (rx_overrun & ~err_clr);
      end
endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed + randomized checks of uart_fifo against a frame-level model.
module tb_uart_fifo;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [15:0] baud_div = 16'd1;
   logic [1:0] parity_mode = 2'd0;
   logic stop2 = 1'b0, tx_wr_en = 1'b0, rx_rd_en = 1'b0, err_clr = 1'b0;
   logic [7:0] tx_wr_data = 8'd0;
   logic tx_full, tx_empty, tx_busy, tx, rx, rx_empty, rx_full, parity_err, frame_err, rx_overrun;
   logic [7:0] rx_rd_data;
   logic rx_drv = 1'b1, loop = 1'b0;
   int total = 0, bad = 0;
   logic [7:0] exp_q[$];
   assign rx = loop ? tx : rx_drv;
   always #5 clk = ~clk;
   uart_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .parity_mode(parity_mode), .stop2(stop2),
      .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .tx_full(tx_full), .tx_empty(tx_empty),
      .tx_busy(tx_busy), .tx(tx), .rx(rx), .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data),
      .rx_empty(rx_empty), .rx_full(rx_full), .parity_err(parity_err), .frame_err(frame_err),
      .rx_overrun(rx_overrun), .err_clr(err_clr)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   // serial image of one frame, index 0 = start bit
   function automatic int frame(input logic [7:0] d, input logic [1:0] pm, input logic s2, output logic [11:0] bits);
      int n;
      bits = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1+i] = d[i];
      n = 9;
      if (pm == 2'd1 || pm == 2'd2) begin
         bits[n] = (^d) ^ (pm == 2'd2);
         n++;
      end
      return n + (s2 ? 2 : 1);
   endfunction
   task automatic push(input logic [7:0] b);
      tx_wr_en = 1'b1;
      tx_wr_data = b;
      cyc(1);
      tx_wr_en = 1'b0;
   endtask
   task automatic check_frame(input string tag, input logic [7:0] d, output int w);
      logic [11:0] bits;
      int n, ones, len;
      n = frame(d, parity_mode, stop2, bits);
      len = 16 * int'(baud_div);
      w = 0;
      while (tx !== 1'b0 && w < 4000) begin
         cyc(1);
         w++;
      end
      chk({tag, "_start"}, tx, 1'b0);
      for (int i = 0; i < n; i++) begin
         ones = 0;
         for (int j = 0; j < len; j++) begin
            ones += int'(tx);
            cyc(1);
         end
         chk($sformatf("%s_bit%0d", tag, i), ones, bits[i] ? len : 0);
      end
   endtask
   task automatic inject(input logic [7:0] d, input logic [1:0] pm, input logic flip, input logic stop_val);
      logic [11:0] bits;
      int n;
      n = frame(d, pm, 1'b0, bits);
      if (flip) bits[9] = ~bits[9];
      bits[n-1] = stop_val;
      for (int i = 0; i < n; i++) begin
         rx_drv = bits[i];
         cyc(16 * int'(baud_div));
      end
      cyc(4);
   endtask
   task automatic pop_check(input string tag, input logic [7:0] exp);
      chk(tag, rx_rd_data, exp);
      rx_rd_en = 1'b1;
      cyc(1);
      rx_rd_en = 1'b0;
   endtask
   task automatic wait_idle();
      int w = 0;
      while (tx_busy && w < 20000) begin
         cyc(1);
         w++;
      end
      chk("tx_drain", tx_busy, 1'b0);
      cyc(80);
   endtask
   initial begin
      logic [7:0] b0, b1;
      int w;
      cyc(3);
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", tx_busy, 1'b0);
      chk("rst_tx_empty", tx_empty, 1'b1);
      chk("rst_rx_empty", rx_empty, 1'b1);
      chk("rst_fulls", {tx_full, rx_full}, 2'b00);
      chk("rst_flags", {parity_err, frame_err, rx_overrun}, 3'b000);
      chk("rst_rd_data", rx_rd_data, 8'h00);
      rst_n = 1'b1;
      cyc(2);
      // basic 8N1 frame at full tick rate
      push(8'hA5);
      chk("a5_pushed", {tx, tx_empty}, 2'b10);
      cyc(1);
      chk("a5_latency", tx, 1'b0);
      chk("a5_popped", tx_empty, 1'b1);
      check_frame("a5", 8'hA5, w);
      chk("a5_done_busy", tx_busy, 1'b0);
      chk("a5_done_tx", tx, 1'b1);
      // random format, back-to-back frames
      baud_div = 16'd3;
      parity_mode = 2'($urandom_range(0, 3));
      stop2 = 1'($urandom_range(0, 1));
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      push(b0);
      push(b1);
      check_frame("b2b_0", b0, w);
      check_frame("b2b_1", b1, w);
      chk("b2b_gap", w, 0);
      chk("b2b_busy", tx_busy, 1'b0);
      // loopback with even parity, then random formats
      loop = 1'b1;
      baud_div = 16'd2;
      parity_mode = 2'd1;
      stop2 = 1'b0;
      push(8'h00);
      push(8'hFF);
      push(8'h3C);
      wait_idle();
      pop_check("lb_0", 8'h00);
      pop_check("lb_1", 8'hFF);
      pop_check("lb_2", 8'h3C);
      chk("lb_flags", {parity_err, frame_err, rx_overrun}, 3'b000);
      chk("lb_empty", rx_empty, 1'b1);
      for (int k = 0; k < 2; k++) begin
         parity_mode = 2'($urandom_range(0, 3));
         stop2 = 1'($urandom_range(0, 1));
         for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'($urandom));
            push(exp_q[$]);
         end
         wait_idle();
         while (exp_q.size() > 0) pop_check("lb_rand", exp_q.pop_front());
         chk("lb_rand_flags", {parity_err, frame_err, rx_overrun, rx_empty}, 4'b0001);
      end
      // parity error still stores the byte
      loop = 1'b0;
      baud_div = 16'd1;
      parity_mode = 2'd1;
      stop2 = 1'b0;
      cyc(10);
      inject(8'h55, 2'd1, 1'b1, 1'b1);
      chk("par_stored", rx_empty, 1'b0);
      chk("par_err", {parity_err, frame_err}, 2'b10);
      err_clr = 1'b1;
      cyc(1);
      err_clr = 1'b0;
      chk("par_clr", parity_err, 1'b0);
      pop_check("par_data", 8'h55);
      b0 = 8'($urandom);
      inject(b0, 2'd1, 1'b0, 1'b1);
      chk("par_good", parity_err, 1'b0);
      pop_check("par_good_data", b0);
      // overrun on a full RX FIFO
      parity_mode = 2'd0;
      for (int i = 0; i < 5; i++) begin
         b0 = 8'($urandom);
         if (exp_q.size() < 4) exp_q.push_back(b0);
         inject(b0, 2'd0, 1'b0, 1'b1);
         if (i == 3) chk("ovr_full_no_flag", {rx_full, rx_overrun}, 2'b10);
      end
      chk("ovr_flag", {rx_full, rx_overrun}, 2'b11);
      while (exp_q.size() > 0) pop_check("ovr_data", exp_q.pop_front());
      chk("ovr_empty", rx_empty, 1'b1);
      err_clr = 1'b1;
      cyc(1);
      err_clr = 1'b0;
      // short low glitch is rejected
      rx_drv = 1'b0;
      cyc(4);
      rx_drv = 1'b1;
      cyc(200);
      chk("glitch", {rx_empty, frame_err}, 2'b10);
      // broken stop bit: frame error, nothing stored, then recovery
      inject(8'($urandom), 2'd0, 1'b0, 1'b0);
      cyc(40);
      chk("ferr", {rx_empty, frame_err}, 2'b11);
      rx_drv = 1'b1;
      cyc(20);
      b0 = 8'($urandom);
      inject(b0, 2'd0, 1'b0, 1'b1);
      pop_check("ferr_recover", b0);
      // asynchronous reset in the middle of a loopback burst
      loop = 1'b1;
      b0 = 8'($urandom);
      push(b0);
      push(8'($urandom));
      push(8'($urandom));
      w = 0;
      while (rx_empty && w < 1000) begin
         cyc(1);
         w++;
      end
      chk("rst_pre_rx", rx_rd_data, b0);
      cyc(40);
      chk("rst_pre_busy", {tx_busy, frame_err}, 2'b11);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_tx", tx, 1'b1);
      chk("arst_state", {tx_busy, tx_empty, rx_empty, tx_full, rx_full}, 5'b01100);
      chk("arst_flags", {parity_err, frame_err, rx_overrun}, 3'b000);
      chk("arst_rd_data", rx_rd_data, 8'h00);
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc(2);
      b1 = 8'($urandom);
      push(b1);
      check_frame("post_rst", b1, w);
      cyc(30);
      pop_check("post_rst_rx", b1);
      chk("post_rst_empty", rx_empty, 1'b1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
